ex_mem_pipe_reg: RTL

//  EX->MEM pipeline register feeding the memory-access stage.

---
 rtl/ex_mem_pipe_reg.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// ============================================================================
// Module   : ex_mem_pipe_reg
// Purpose  : EX->MEM pipeline register with 2-entry skid buffer, flush and
//            back-pressure counter. Optional ALIGN_CHECK_EN macro enables
//            misaligned-access tagging at capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe_reg #(
  parameter int          DATA_W = 32,
  parameter int          CNT_W  = 32,
  parameter logic [3:0]  NOP_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  input  logic              in_rw_en,
  input  logic [4:0]        in_rw_addr,
  input  logic [3:0]        in_lsu_op,
  input  logic [DATA_W-1:0] in_lsu_data,
  input  logic [DATA_W-1:0] in_ex_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic              out_rw_en,
  output logic [4:0]        out_rw_addr,
  output logic [3:0]        out_lsu_op,
  output logic [DATA_W-1:0] out_lsu_data,
  output logic [DATA_W-1:0] out_ex_result,
  output logic              out_ale,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              rw_en;
    logic [4:0]        rw_addr;
    logic [3:0]        lsu_op;
    logic [DATA_W-1:0] lsu_data;
    logic [DATA_W-1:0] ex_result;
    logic              ale;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  bundle_t          r_m;
  bundle_t          r_s;
  bundle_t          w_cap;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_in_xfer;
  logic             w_out_xfer;

`ifdef ALIGN_CHECK_EN
  localparam logic [3:0] c_ld_h  = 4'b0001;
  localparam logic [3:0] c_ld_w  = 4'b0010;
  localparam logic [3:0] c_st_h  = 4'b0101;
  localparam logic [3:0] c_st_w  = 4'b0110;
  localparam logic [3:0] c_ld_hu = 4'b1001;
  logic w_misalign;
`endif

  // Capture view of the incoming bundle; misaligned accesses become non-memory ops
  always_comb begin
    w_cap.pc        = in_pc;
    w_cap.inst      = in_inst;
    w_cap.rw_addr   = in_rw_addr;
    w_cap.lsu_data  = in_lsu_data;
    w_cap.ex_result = in_ex_result;
`ifdef ALIGN_CHECK_EN
    w_misalign = (((in_lsu_op == c_ld_h) || (in_lsu_op == c_ld_hu) || (in_lsu_op == c_st_h))
                  && in_ex_result[0])
              || (((in_lsu_op == c_ld_w) || (in_lsu_op == c_st_w))
                  && (in_ex_result[1:0] != 2'b00));
    w_cap.rw_en  = w_misalign ? 1'b0 : in_rw_en;
    w_cap.lsu_op = w_misalign ? NOP_OP : in_lsu_op;
    w_cap.ale    = w_misalign;
`else
    w_cap.rw_en  = in_rw_en;
    w_cap.lsu_op = in_lsu_op;
    w_cap.ale    = 1'b0;
`endif
  end

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_m            <= '0;
      r_m.lsu_op     <= NOP_OP;
      r_s            <= '0;
      r_s.lsu_op     <= NOP_OP;
      r_stall_cnt    <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;

      if (flush) begin
        r_state      <= ST_EMPTY;
        r_in_ready   <= 1'b1;
        r_m.rw_en    <= 1'b0;
        r_m.lsu_op   <= NOP_OP;
        r_m.ale      <= 1'b0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              r_m     <= w_cap;
              r_state <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              r_m <= w_cap;
            end else if (w_in_xfer) begin
              r_s        <= w_cap;
              r_in_ready <= 1'b0;
              r_state    <= ST_TWO;
            end else if (w_out_xfer) begin
              r_m.rw_en  <= 1'b0;
              r_m.lsu_op <= NOP_OP;
              r_m.ale    <= 1'b0;
              r_state    <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_out_xfer) begin
              r_m        <= r_s;
              r_in_ready <= 1'b1;
              r_state    <= ST_ONE;
            end
          end
          default: begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = (r_state != ST_EMPTY);
  assign out_pc         = r_m.pc;
  assign out_inst       = r_m.inst;
  assign out_rw_en      = r_m.rw_en;
  assign out_rw_addr    = r_m.rw_addr;
  assign out_lsu_op     = r_m.lsu_op;
  assign out_lsu_data   = r_m.lsu_data;
  assign out_ex_result  = r_m.ex_result;
  assign out_ale        = r_m.ale;
  assign perf_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
